delay_timer_param: RTL and testbench

// - Parametrised programmable interval timer for the traffic-light controller.
// - Divides clk down to a tick of TICK_HZ, then counts a loaded number of ticks
//   and emits a one-cycle timeout pulse.
// - Supports one-shot and periodic modes, pause, cancel and restart.
// - Sits between the phase FSM, which drives start/delay, and the light outputs.

---
 rtl/delay_timer_param.sv | 120 ++++++++++++
 tb/tb_delay_timer_param.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/delay_timer_param.sv
// Programmable interval timer: prescales clk to a tick, counts loaded ticks, pulses timeout.
// Optional done/ack latch enabled by defining DELAY_TIMER_DONE_LATCH_EN.
module delay_timer_param #(
   parameter int unsigned CLK_FREQ_HZ = 50000000,
   parameter int unsigned TICK_HZ     = 1,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] delay,
   input  logic             mode,
   input  logic             pause,
   input  logic             cancel,
   output logic             busy,
   output logic             timeout,
   output logic [CNT_W-1:0] remaining
`ifdef DELAY_TIMER_DONE_LATCH_EN
   ,
   input  logic             ack,
   output logic             done
`endif
);

   localparam int unsigned PRESCALE = CLK_FREQ_HZ / TICK_HZ;
   localparam int unsigned PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t           r_state;
   logic [PRE_W-1:0] r_pre_cnt;
   logic [CNT_W-1:0] r_remaining;
   logic [CNT_W-1:0] r_delay_q;
   logic             r_mode_q;
   logic             r_timeout;
   logic             r_busy;

   logic w_tick;
   logic w_expire;
   logic w_zero_start;
   logic w_fire;

   // Expiry and zero-delay start are the only sources of a timeout pulse.
   assign w_tick       = (r_state == ST_RUN) && !pause && (r_pre_cnt == PRE_W'(PRESCALE - 1));
   assign w_expire     = w_tick && (r_remaining == CNT_W'(1)) && !cancel && !start;
   assign w_zero_start = start && !cancel && (delay == '0);
   assign w_fire       = w_expire || w_zero_start;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_pre_cnt   <= '0;
         r_remaining <= '0;
         r_delay_q   <= '0;
         r_mode_q    <= 1'b0;
         r_timeout   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_timeout <= w_fire;
         if (cancel) begin
            r_state     <= ST_IDLE;
            r_pre_cnt   <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
         end else if (start) begin
            r_pre_cnt <= '0;
            if (delay != '0) begin
               r_state     <= ST_RUN;
               r_delay_q   <= delay;
               r_mode_q    <= mode;
               r_remaining <= delay;
               r_busy      <= 1'b1;
            end else begin
               r_state     <= ST_IDLE;
               r_remaining <= '0;
               r_busy      <= 1'b0;
            end
         end else if (r_state == ST_RUN && !pause) begin
            if (w_tick) begin
               r_pre_cnt <= '0;
               if (r_remaining == CNT_W'(1)) begin
                  if (r_mode_q) begin
                     r_remaining <= r_delay_q;
                  end else begin
                     r_state     <= ST_IDLE;
                     r_remaining <= '0;
                     r_busy      <= 1'b0;
                  end
               end else if (r_remaining != '0) begin
                  r_remaining <= r_remaining - CNT_W'(1);
               end
            end else begin
               r_pre_cnt <= r_pre_cnt + PRE_W'(1);
            end
         end
      end
   end

   assign busy      = r_busy;
   assign timeout   = r_timeout;
   assign remaining = r_remaining;

`ifdef DELAY_TIMER_DONE_LATCH_EN
   logic r_done;

   // Sticky completion flag; a fresh timeout beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_done <= 1'b0;
      end else if (w_fire) begin
         r_done <= 1'b1;
      end else if (ack || start) begin
         r_done <= 1'b0;
      end
   end

   assign done = r_done;
`endif

endmodule

// File: tb/tb_delay_timer_param.sv
// Bench for delay_timer_param with PRESCALE=10: directed table plus random stimulus vs a cycle-budget model.
module tb_delay_timer_param;

   localparam int unsigned P     = 10;
   localparam int unsigned CNT_W = 32;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] delay = '0;
   logic             mode = 1'b0;
   logic             pause = 1'b0;
   logic             cancel = 1'b0;
   logic             busy;
   logic             timeout;
   logic [CNT_W-1:0] remaining;
`ifdef DELAY_TIMER_DONE_LATCH_EN
   logic             ack = 1'b0;
   logic             done;
`endif

   delay_timer_param #(.CLK_FREQ_HZ(10), .TICK_HZ(1), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .start(start), .delay(delay), .mode(mode),
      .pause(pause), .cancel(cancel), .busy(busy), .timeout(timeout),
      .remaining(remaining)
`ifdef DELAY_TIMER_DONE_LATCH_EN
      , .ack(ack), .done(done)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             rst;
      logic             st;
      logic [CNT_W-1:0] dl;
      logic             md;
      logic             ps;
      logic             cn;
      int               reps;
      logic             e_to;
      logic             e_busy;
      logic [CNT_W-1:0] e_rem;
   } vec_t;

   vec_t vecs[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: cycles left until expiry; remaining is the ceiling in ticks.
   bit          m_run = 0;
   longint      m_left = 0;
   longint      m_dq = 0;
   bit          m_mq = 0;
   bit          m_to = 0;

   task automatic check(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_step();
      m_to = 0;
      if (reset || cancel) begin
         m_run = 0; m_left = 0;
      end else if (start) begin
         if (delay != 0) begin
            m_run = 1; m_left = longint'(delay) * P; m_dq = longint'(delay); m_mq = mode;
         end else begin
            m_to = 1; m_run = 0; m_left = 0;
         end
      end else if (m_run && !pause) begin
         m_left--;
         if (m_left == 0) begin
            m_to = 1;
            if (m_mq) m_left = m_dq * P;
            else m_run = 0;
         end
      end
   endtask

   function automatic logic [CNT_W-1:0] m_rem();
      return CNT_W'((m_left + P - 1) / P);
   endfunction

   // One clock: inputs already driven; update model at the edge, compare just after.
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check("model_timeout", {31'd0, timeout}, {31'd0, m_to});
      check("model_busy", {31'd0, busy}, {31'd0, m_run});
      check("model_remaining", remaining, m_rem());
   endtask

   task automatic add(input logic r, input logic s, input int d, input logic md, input logic ps,
                      input logic cn, input int reps, input logic eto, input logic eb, input int er);
      vec_t v;
      v.rst = r; v.st = s; v.dl = CNT_W'(d); v.md = md; v.ps = ps; v.cn = cn; v.reps = reps;
      v.e_to = eto; v.e_busy = eb; v.e_rem = CNT_W'(er);
      vecs.push_back(v);
   endtask

   initial begin
      //  rst st  dl md ps cn reps   to busy rem
      add(1, 0, 0, 0, 0, 0, 1,     0, 0, 0);   // reset state
      // one-shot delay 3
      add(0, 1, 3, 0, 0, 0, 1,     0, 1, 3);
      add(0, 0, 9, 1, 0, 0, 9,     0, 1, 3);   // delay/mode changes ignored
      add(0, 0, 0, 0, 0, 0, 1,     0, 1, 2);
      add(0, 0, 0, 0, 0, 0, 19,    0, 1, 1);
      add(0, 0, 0, 0, 0, 0, 1,     1, 0, 0);   // E0+30
      add(0, 0, 0, 0, 0, 0, 1,     0, 0, 0);
      // periodic delay 2
      add(0, 1, 2, 1, 0, 0, 1,     0, 1, 2);
      add(0, 0, 0, 0, 0, 0, 19,    0, 1, 1);
      add(0, 0, 0, 0, 0, 0, 1,     1, 1, 2);   // E0+20
      add(0, 0, 0, 0, 0, 0, 19,    0, 1, 1);
      add(0, 0, 0, 0, 0, 0, 1,     1, 1, 2);   // E0+40
      add(0, 0, 0, 0, 0, 0, 19,    0, 1, 1);
      add(0, 0, 0, 0, 0, 0, 1,     1, 1, 2);   // E0+60
      add(0, 0, 0, 0, 0, 1, 1,     0, 0, 0);   // cancel
      add(0, 0, 0, 0, 1, 1, 3,     0, 0, 0);   // pause/cancel in IDLE
      // pause extends expiry
      add(0, 1, 1, 0, 0, 0, 1,     0, 1, 1);
      add(0, 0, 0, 0, 0, 0, 4,     0, 1, 1);
      add(0, 0, 0, 0, 1, 0, 5,     0, 1, 1);
      add(0, 0, 0, 0, 0, 0, 5,     0, 1, 1);
      add(0, 0, 0, 0, 0, 0, 1,     1, 0, 0);   // E0+15
      // cancel with start on the same edge
      add(0, 1, 2, 0, 0, 0, 1,     0, 1, 2);
      add(0, 0, 0, 0, 0, 0, 6,     0, 1, 2);
      add(0, 1, 5, 0, 0, 1, 1,     0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 40,    0, 0, 0);
      // restart
      add(0, 1, 3, 0, 0, 0, 1,     0, 1, 3);
      add(0, 0, 0, 0, 0, 0, 24,    0, 1, 1);
      add(0, 1, 1, 0, 0, 0, 1,     0, 1, 1);   // E0+25
      add(0, 0, 0, 0, 0, 0, 9,     0, 1, 1);
      add(0, 0, 0, 0, 0, 0, 1,     1, 0, 0);   // E0+35
      add(0, 0, 0, 0, 0, 0, 1,     0, 0, 0);
      // zero delay from IDLE and from RUN
      add(0, 1, 0, 1, 0, 0, 1,     1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1,     0, 0, 0);
      add(0, 1, 3, 1, 0, 0, 1,     0, 1, 3);
      add(0, 1, 0, 1, 0, 0, 1,     1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 30,    0, 0, 0);
      // expiry edge overridden by cancel
      add(0, 1, 1, 0, 0, 0, 1,     0, 1, 1);
      add(0, 0, 0, 0, 0, 0, 9,     0, 1, 1);
      add(0, 0, 0, 0, 0, 1, 1,     0, 0, 0);
      // reset mid-run
      add(0, 1, 4, 1, 0, 0, 1,     0, 1, 4);
      add(0, 0, 0, 0, 0, 0, 5,     0, 1, 4);
      add(1, 0, 0, 0, 0, 0, 1,     0, 0, 0);

      foreach (vecs[i]) begin
         reset = vecs[i].rst; start = vecs[i].st; delay = vecs[i].dl;
         mode = vecs[i].md; pause = vecs[i].ps; cancel = vecs[i].cn;
         for (int k = 0; k < vecs[i].reps; k++) cycle();
         check($sformatf("vec%0d_timeout", i), {31'd0, timeout}, {31'd0, vecs[i].e_to});
         check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
         check($sformatf("vec%0d_remaining", i), remaining, vecs[i].e_rem);
      end

      // Random traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         reset  = ($urandom_range(0, 399) == 0);
         start  = ($urandom_range(0, 24) == 0);
         delay  = CNT_W'($urandom_range(0, 4));
         mode   = 1'($urandom_range(0, 1));
         pause  = ($urandom_range(0, 4) == 0);
         cancel = ($urandom_range(0, 79) == 0);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
